// File: rtl/matram_row_collector_if.sv
// Bus bundle between the MatRAM lane sequencer side, the row collector and
// the MAU compute datapath. The master drives read words and control
// strobes and consumes rows; the slave is the collector itself.
interface matram_row_collector_if #(
  parameter int WORD_W = 16
);
  logic                  mau_start;
  logic                  data_valid;
  logic [WORD_W-1:0]     data_in;
  logic                  row_ready;
  logic                  err_clear;
  logic [4*WORD_W-1:0]   row_data;
  logic                  row_valid;
  logic [1:0]            row_count;
  logic                  busy;
  logic                  overflow;
  logic                  short_burst;

  modport master (
    output mau_start, data_valid, data_in, row_ready, err_clear,
    input  row_data, row_valid, row_count, busy, overflow, short_burst
  );

  modport slave (
    input  mau_start, data_valid, data_in, row_ready, err_clear,
    output row_data, row_valid, row_count, busy, overflow, short_burst
  );
endinterface

// File: rtl/matram_row_collector.sv
// Packs bursts of four MatRAM read words into 64-bit rows and buffers them
// in a 2-entry FIFO toward the MAU compute datapath. Sticky flags record
// rows dropped on a full FIFO and bursts restarted before completion.
module matram_row_collector #(
  parameter int WORD_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  matram_row_collector_if.slave bus
);
  localparam int         ROW_W      = 4 * WORD_W;
  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  // Burst packing state
  logic [1:0]        idx_reg, idx_next;
  logic [1:0]        wr_slot;
  logic              push_req;
  logic              short_set;
  logic [ROW_W-1:0]  push_row;

  // Row FIFO state
  logic [ROW_W-1:0]  mem_reg [DEPTH];
  logic              wr_ptr_reg, rd_ptr_reg;
  logic [1:0]        count_reg, count_next;
  logic              full;
  logic              pop;
  logic              push_ok;
  logic              drop;

  // Sticky error flags
  logic              overflow_reg, short_burst_reg;

  // Word index update, slot selection and row completion detection
  always_comb begin
    idx_next  = idx_reg;
    wr_slot   = idx_reg;
    push_req  = 1'b0;
    short_set = 1'b0;
    if (bus.mau_start) begin
      // A restart abandons any partial row; a word arriving with it is word 0.
      short_set = (idx_reg != 2'd0);
      wr_slot   = 2'd0;
      idx_next  = bus.data_valid ? 2'd1 : 2'd0;
    end else if (bus.data_valid) begin
      idx_next = idx_reg + 2'd1;
      push_req = (idx_reg == 2'd3);
    end
  end

  // Packing slots hold words 0..2; word 3 goes straight into the pushed row
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_slot
      logic [WORD_W-1:0] slot_reg;
      // Capture the incoming word when it targets this slot
      always_ff @(posedge clk) begin
        if (bus.data_valid && (wr_slot == 2'(gi))) begin
          slot_reg <= bus.data_in;
        end
      end
    end
  endgenerate

  assign push_row = {bus.data_in, g_slot[2].slot_reg, g_slot[1].slot_reg, g_slot[0].slot_reg};

  // FIFO handshake: a full FIFO still accepts a row if the head leaves this cycle
  always_comb begin
    full       = (count_reg == FULL_COUNT);
    pop        = (count_reg != 2'd0) && bus.row_ready;
    push_ok    = push_req && (!full || pop);
    drop       = push_req && !push_ok;
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // FIFO storage write; contents are don't-care until pushed, so no reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= push_row;
    end
  end

  // Control state: word index, FIFO pointers and occupancy, sticky flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_reg         <= 2'd0;
      wr_ptr_reg      <= 1'b0;
      rd_ptr_reg      <= 1'b0;
      count_reg       <= 2'd0;
      overflow_reg    <= 1'b0;
      short_burst_reg <= 1'b0;
    end else begin
      idx_reg   <= idx_next;
      count_reg <= count_next;
      if (push_ok) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      // A new event in the same cycle as err_clear keeps the flag set.
      overflow_reg    <= drop      ? 1'b1 : (bus.err_clear ? 1'b0 : overflow_reg);
      short_burst_reg <= short_set ? 1'b1 : (bus.err_clear ? 1'b0 : short_burst_reg);
    end
  end

  assign bus.row_data    = mem_reg[rd_ptr_reg];
  assign bus.row_valid   = (count_reg != 2'd0);
  assign bus.row_count   = count_reg;
  assign bus.busy        = (idx_reg != 2'd0);
  assign bus.overflow    = overflow_reg;
  assign bus.short_burst = short_burst_reg;
endmodule
